// File: rtl/sum_pkg.sv
// Shared definitions for the round-robin summation scheduler: FSM encoding,
// default widths and the result-width helper.
package sum_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int TW_DEF = 5;

  // (2^tw-1)*2^(tw-1) is the largest sum of 0..targ and always fits in 2*tw-1 bits.
  function automatic int sum_width(input int tw);
    return 2 * tw - 1;
  endfunction

  localparam int SW_DEF = sum_width(TW_DEF);

endpackage

// File: rtl/sum_engine.sv
// Iterative accumulator computing 0+1+...+targ, one term per enabled step.
module sum_engine
#(
  parameter int TW = 5,
  parameter int SW = 9
)
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  input  logic [TW-1:0] targ,
  output logic          last,
  output logic [SW-1:0] acc
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (clear) begin
      cnt <= '0;
      acc <= '0;
    end else if (step) begin
      acc <= acc + SW'(cnt);
      cnt <= cnt + TW'(1);
    end
  end

  // The current step adds the final term when the counter has reached the target.
  assign last = (cnt == targ);

endmodule

// File: rtl/sum_job_sched.sv
// Round-robin scheduler sharing one sum_engine among N_REQ requesters; all
// outputs are registered.
module sum_job_sched
  import sum_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TW    = TW_DEF,
  parameter int SW    = sum_width(TW),
  parameter int IDW   = $clog2(N_REQ)
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*TW-1:0] targ_bus,
  input  logic                pause,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    ack,
  output logic [SW-1:0]       result,
  output logic                result_valid,
  output logic [IDW-1:0]      result_id,
  output logic                busy
);

  logic [1:0]     state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id_l;
  logic [TW-1:0]  targ_l;

  logic           win_vld;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] arb_id;

  logic           eng_clear;
  logic           eng_step;
  logic           eng_last;
  logic [SW-1:0]  eng_acc;

  // Scan from rr_ptr downward in priority so the lowest offset is written last and wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    arb_id  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      arb_id = IDW'((int'(rr_ptr) + k) % N_REQ);
      if (req[arb_id]) begin
        win_vld = 1'b1;
        win_id  = arb_id;
      end
    end
  end

  assign eng_clear = (state == ST_GRANT);
  assign eng_step  = (state == ST_RUN) && !pause;

  sum_engine #(
    .TW (TW),
    .SW (SW)
  ) u_engine (
    .clk   (clk),
    .rst   (rst),
    .clear (eng_clear),
    .step  (eng_step),
    .targ  (targ_l),
    .last  (eng_last),
    .acc   (eng_acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      id_l         <= '0;
      targ_l       <= '0;
      gnt          <= '0;
      ack          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      result_id    <= '0;
      busy         <= 1'b0;
    end else begin
      gnt          <= '0;
      ack          <= '0;
      result_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            id_l   <= win_id;
            targ_l <= targ_bus[int'(win_id)*TW +: TW];
            gnt    <= {{(N_REQ-1){1'b0}}, 1'b1} << win_id;
            busy   <= 1'b1;
            state  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          // Register the final sum as the last term is added so result lands in DONE.
          if (eng_step && eng_last) begin
            result       <= eng_acc + SW'(targ_l);
            result_id    <= id_l;
            result_valid <= 1'b1;
            ack          <= {{(N_REQ-1){1'b0}}, 1'b1} << id_l;
            state        <= ST_DONE;
          end
        end
        default: begin
          rr_ptr <= (id_l == IDW'(N_REQ - 1)) ? '0 : id_l + IDW'(1);
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sum_job_sched.md
# sum_job_sched

Round-robin scheduler that shares one iterative summation engine (sum of 0..targ) between several requesters. Each requester raises a request with its own target. The scheduler grants one at a time, sequences the engine, and returns the result with the winner's ID and a per-requester acknowledge. It sits between the board-level input channels and the single shared accumulator datapath.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `TW`, default 5: target width.
- `SW`, default 9: result width; must satisfy SW ≥ 2*TW-1 (max sum 31*32/2 = 496).
- `IDW`, default $clog2(N_REQ): requester ID width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input N_REQ: per-requester request; level, held until matching `ack`.
- `targ_bus` input N_REQ*TW: requester i target at bits [i*TW +: TW].
- `pause` input 1: when high during RUN, the engine holds (no add, no count).
- `gnt` output N_REQ: one-hot, one-cycle pulse when a requester is selected.
- `ack` output N_REQ: one-hot, one-cycle pulse with `result_valid`.
- `result` output SW: sum 0+1+…+targ of the served job; held until the next DONE.
- `result_valid` output 1: one-cycle pulse in DONE.
- `result_id` output IDW: ID of the served requester; held with `result`.
- `busy` output 1: high in GRANT, RUN and DONE.

## Operation
- States: IDLE, GRANT, RUN, DONE (encoding constants live in the package).
- IDLE: if any `req` bit is high, select the winner by round-robin starting at pointer `rr_ptr`. Latch its ID and target, then go to GRANT. Otherwise stay in IDLE.
- GRANT: assert `gnt[id]`, clear the engine (cnt=0, acc=0), go to RUN. The target is already latched, so later `targ_bus` changes are ignored.
- RUN, each cycle with `pause`=0:
  - acc ← acc + cnt; cnt ← cnt + 1.
  - When cnt == targ_l on that cycle, go to DONE after this add.
- RUN with `pause`=1: acc and cnt hold and the state stays in RUN.
- DONE: `result` ← acc, `result_id` ← id, `result_valid`=1, `ack[id]`=1, `rr_ptr` ← id+1 mod N_REQ, then go to IDLE.
- Arithmetic: unsigned. The accumulator is SW bits wide and never overflows for legal parameters.
- If `req[id]` drops mid-job, the job still completes and is acked; the requester ignores the ack.
- Simultaneous requests: the lowest index at or above `rr_ptr` wins, wrapping at N_REQ-1 → 0.
- A requester still holding `req` in the cycle after `ack` is treated as a new request.
- `pause` in IDLE, GRANT or DONE has no effect.
- Reset (any time, including mid-RUN): all outputs 0, state IDLE, rr_ptr=0, acc=0, cnt=0, latched target/ID=0. The interrupted job is dropped with no ack.

## Timing
- `req` first high in IDLE at cycle c → `gnt` pulse in cycle c+1 (GRANT).
- RUN occupies cycles c+2 … c+2+targ, i.e. targ+1 cycles with no pause; each pause cycle adds one.
- `result_valid`/`ack` pulse at cycle c+3+targ; `busy` falls the following cycle.
- Back-to-back: IDLE at c+4+targ samples the next request. Minimum job-to-job period is targ+4 cycles.
- All outputs are registered.

## Structure
- Package `sum_pkg`: state enum/localparams (IDLE, GRANT, RUN, DONE), default TW/SW, and a function for maximum sum width.
- Sub-module `sum_engine`: holds cnt and acc, with inputs clear, step, targ and outputs last and acc. It is a reusable datapath.
- `sum_job_sched`: state machine, round-robin arbiter, latches and output registers.

## Test plan
- Reset → all outputs 0. Then single req[0], targ=4 → gnt[0] at c+1, ack[0] and result_valid at c+7, result=10, result_id=0.
- targ=0 on req[2] → one RUN cycle, result=0, ack[2] at c+3. Then targ=31 → result=496 at c+34.
- req[0..3] all high and held, targets 1,2,3,4 → serve order 0,1,2,3,0; results 1,3,6,10.
- Pause high for 3 cycles mid-RUN, targ=5 → result=15, and ack arrives exactly 3 cycles later than without pause.
- Assert rst mid-RUN of a targ=20 job → outputs 0 immediately, no ack. After release, re-request with targ=3 → result=6, rr order restarts at 0.
- Change targ_bus and drop req[1] during its RUN (latched targ=6) → result=21 with ack[1] still pulsed.
